note_scroller: RTL
==================

Name: note_scroller

Overview:
- Parametrised successor of the song note shift/load block for the LED-matrix rhythm game.
- Scrolls a window of colour-coded note cells across the matrix with sub-cell pixel offset.
- Pulls song notes from a valid/ready stream (song ROM feeder) instead of hard-coded song constants.
- Judges player hits at a configurable cell, reports hit/wrong/miss/underrun events, and signals song end after the window drains.

Parameters:
- WINDOW, 10, number of note cells visible; cell 0 exits first, new notes enter at cell WINDOW-1.
- NUM_COLORS, 2, number of note colours; code 0 = empty, codes 1..NUM_COLORS = colours.
- CW, 2, note code width; must satisfy 2^CW > NUM_COLORS.
- OFFSET_STEPS, 7, pixel sub-steps per cell shift (>=1).
- OW, 3, offset width; must satisfy 2^OW >= OFFSET_STEPS.
- TICK_DIV, 50000, clk cycles per offset tick (>=1).
- JUDGE_POS, 1, judged cell index (0..WINDOW-1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a song from IDLE.
- pause  in  1  level; freezes prescaler, offset and window.
- note_valid  in  1  feeder has a note.
- note_data  in  CW  note code.
- note_last  in  1  marks final note of song.
- note_ready  out  1  note accepted this cycle when note_valid=1.
- hit_valid  in  1  one-cycle player hit.
- hit_code  in  CW  colour the player hit.
- color_mask  out  NUM_COLORS*WINDOW  bit [(c-1)*WINDOW+i] = 1 iff cell i holds code c.
- offset  out  OW  current pixel offset, 0..OFFSET_STEPS-1.
- judge_code  out  CW  code in cell JUDGE_POS.
- hit_ok  out  1  pulse: correct hit.
- hit_bad  out  1  pulse: hit on empty cell or wrong colour.
- miss  out  1  pulse: non-empty note left the judge cell unhit.
- underrun  out  1  pulse: step occurred with no note available.
- busy  out  1  high in RUN or DRAIN.
- finish  out  1  one-cycle pulse at song end.

Behaviour:
- Reset (rst=0 at clock edge): state IDLE; all cells 0; prescaler, offset and drain counter 0; every output 0. Reset has priority over all inputs and aborts a song mid-operation.
- States:
  - IDLE: start=1 -> clear cells, prescaler and offset -> RUN.
  - RUN: note_last accepted on a step -> DRAIN.
  - DRAIN: after WINDOW further steps -> DONE.
  - DONE: finish=1 for this cycle -> IDLE.
  - start is ignored outside IDLE.
- Tick: in RUN/DRAIN with pause=0, prescaler counts 0..TICK_DIV-1; tick when prescaler = TICK_DIV-1, then it wraps to 0.
- On tick: if offset = OFFSET_STEPS-1, offset <= 0 and a step occurs; otherwise offset <= offset+1.
- Step: cell[i] <= cell[i+1] for i < WINDOW-1; cell 0 is discarded; cell[WINDOW-1] receives the incoming code.
- Incoming code on a step:
  - RUN, note_valid=1: note_data is taken. A code > NUM_COLORS is stored as 0.
  - RUN, note_valid=0: 0 is inserted and underrun pulses.
  - DRAIN: 0 is inserted; note_ready stays 0.
- note_ready = 1 only in RUN on a step cycle (combinational with the step). A transfer is note_valid & note_ready.
- Hit, evaluated against the pre-step cell[JUDGE_POS]:
  - hit_code = cell != 0 -> hit_ok, cell cleared.
  - Otherwise -> hit_bad, no change.
  - hit_valid is ignored in IDLE, in DONE, and while paused.
- Miss: on a step where pre-step cell[JUDGE_POS] != 0 and no hit_ok that cycle, miss pulses. The note keeps scrolling toward cell 0.
- Hit and step in the same cycle: the hit clears the old judge note and suppresses its miss. The cell shifting into JUDGE_POS is not affected.
- Pause: no ticks, steps, hits or ready. Timing resumes from the frozen prescaler value.
- Outputs: color_mask, judge_code and offset are registered state decodes with no extra latency. Event pulses are registered, asserted the cycle after their causing edge, and last 1 cycle.
- Latency: first note enters cell WINDOW-1 at the first step, TICK_DIV*OFFSET_STEPS cycles after start.
- finish: asserts WINDOW steps after the note_last step, when the last note has left cell 0.

Test Plan:
- Setup: WINDOW=4, NUM_COLORS=2, CW=2, OFFSET_STEPS=2, OW=1, TICK_DIV=2, JUDGE_POS=1.
- Reset then start; feeder always valid with codes 1,2,0,1 (last on 4th) -> note_ready pulses every 4 cycles; after 4 steps color_mask = {B:0010, R:1001} (bit i = cell i); finish pulses exactly 4 steps after the last accept; busy drops.
- Code 1 reaches cell 1; hit_code=1 one cycle before its next step -> hit_ok, cell 1 cleared, no miss; hit_code=2 instead -> hit_bad, then miss on the step.
- Feeder valid low at a step -> underrun pulse, cell 3 = 0, state stays RUN; the next valid note is accepted on the next step.
- pause held 20 cycles mid-song -> offset, color_mask and the prescaler frozen, no note_ready; release -> timing resumes with identical spacing.
- rst=0 asserted in DRAIN with notes on screen -> next cycle all outputs 0, state IDLE; start pulse in RUN -> ignored.

Source files
------------

// File: rtl/note_scroller_if.sv
// Note stream from the song feeder into the scroller: valid/ready with a last-note marker.
// The feeder owns valid/data/last; the scroller owns ready.
interface note_scroller_if #(
    parameter int unsigned CW = 2
) ();
    logic          note_valid;
    logic [CW-1:0] note_data;
    logic          note_last;
    logic          note_ready;

    modport master (
        output note_valid,
        output note_data,
        output note_last,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_data,
        input  note_last,
        output note_ready
    );
endinterface

// File: rtl/note_scroller.sv
// Scrolling note window for the LED-matrix rhythm game: pulls notes from a stream, shifts them
// toward cell 0 with a sub-cell pixel offset and judges player hits at a fixed cell.
module note_scroller #(
    parameter int unsigned WINDOW       = 10,
    parameter int unsigned NUM_COLORS   = 2,
    parameter int unsigned CW           = 2,
    parameter int unsigned OFFSET_STEPS = 7,
    parameter int unsigned OW           = 3,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned JUDGE_POS    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pause,
    note_scroller_if.slave               note,
    input  logic                         hit_valid,
    input  logic [CW-1:0]                hit_code,
    output logic [NUM_COLORS*WINDOW-1:0] color_mask,
    output logic [OW-1:0]                offset,
    output logic [CW-1:0]                judge_code,
    output logic                         hit_ok,
    output logic                         hit_bad,
    output logic                         miss,
    output logic                         underrun,
    output logic                         busy,
    output logic                         finish
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(WINDOW + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [OW-1:0] OFFSET_MAX = OW'(OFFSET_STEPS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(WINDOW - 1);
    localparam logic [CW-1:0] MAX_CODE   = CW'(NUM_COLORS);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic [OW-1:0] offset_q;
    logic [DW-1:0] drain_q;
    logic [CW-1:0] cell_q [WINDOW];
    logic [CW-1:0] held   [WINDOW];
    logic [CW-1:0] cell_d [WINDOW];

    logic          active, tick, step, hit_en, hit_match;
    logic [CW-1:0] judge, incoming;

    always_comb begin
        active    = ((state_q == StRun) || (state_q == StDrain)) && !pause;
        tick      = active && (presc_q == PRESC_MAX);
        step      = tick && (offset_q == OFFSET_MAX);
        judge     = cell_q[JUDGE_POS];
        hit_en    = active && hit_valid;
        hit_match = hit_en && (judge != '0) && (hit_code == judge);
        // Out-of-range codes from the feeder become empty cells.
        incoming  = '0;
        if ((state_q == StRun) && note.note_valid && (note.note_data <= MAX_CODE)) begin
            incoming = note.note_data;
        end
    end

    // A hit clears the pre-step judge cell; the shift then moves the cleared value along.
    for (genvar i = 0; i < WINDOW; i++) begin : g_next
        assign held[i] = (hit_match && (i == JUDGE_POS)) ? '0 : cell_q[i];
        if (i == WINDOW - 1) begin : g_tail
            assign cell_d[i] = step ? incoming : held[i];
        end else begin : g_body
            assign cell_d[i] = step ? held[i+1] : held[i];
        end
    end

    for (genvar c = 0; c < NUM_COLORS; c++) begin : g_color
        for (genvar i = 0; i < WINDOW; i++) begin : g_cell
            assign color_mask[c*WINDOW+i] = (cell_q[i] == CW'(c + 1));
        end
    end

    assign offset          = offset_q;
    assign judge_code      = cell_q[JUDGE_POS];
    assign note.note_ready = (state_q == StRun) && step;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            offset_q <= '0;
            drain_q  <= '0;
            cell_q   <= '{default: '0};
            hit_ok   <= 1'b0;
            hit_bad  <= 1'b0;
            miss     <= 1'b0;
            underrun <= 1'b0;
            busy     <= 1'b0;
            finish   <= 1'b0;
        end else begin
            hit_ok   <= hit_match;
            hit_bad  <= hit_en && !hit_match;
            miss     <= step && (judge != '0) && !hit_match;
            underrun <= step && (state_q == StRun) && !note.note_valid;
            finish   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StRun;
                        busy     <= 1'b1;
                        presc_q  <= '0;
                        offset_q <= '0;
                        cell_q   <= '{default: '0};
                    end
                end
                StRun, StDrain: begin
                    if (active) begin
                        cell_q  <= cell_d;
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            offset_q <= step ? '0 : offset_q + 1'b1;
                        end
                        if (step) begin
                            if (state_q == StRun) begin
                                if (note.note_valid && note.note_last) begin
                                    state_q <= StDrain;
                                    drain_q <= '0;
                                end
                            end else if (drain_q == DRAIN_LAST) begin
                                state_q <= StDone;
                                busy    <= 1'b0;
                                finish  <= 1'b1;
                            end else begin
                                drain_q <= drain_q + 1'b1;
                            end
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
